// File: rtl/lbp_stream_engine.sv
// lbp_stream_engine: streaming 3x3 Local Binary Pattern engine.
// Pixels are read in raster order into a (2*IMG_W+3)-pixel sliding window.
// One code is written per interior pixel in raster order, and finish is raised
// after the last write.
// Optional feature macro: LBP_BORDER_EN. When it is defined, border addresses
// are also written with 8'h00, so every address is written in ascending order.
module lbp_stream_engine #(
   parameter int IMG_W = 128,
   parameter int IMG_H = 128,
   parameter int DW    = 8,
   parameter int AW    = 14
) (
   input  logic          clk,
   input  logic          reset,
   output logic [AW-1:0] gray_addr,
   output logic          gray_req,
   input  logic          gray_ready,
   input  logic [DW-1:0] gray_data,
   output logic [AW-1:0] lbp_addr,
   output logic          lbp_valid,
   output logic [7:0]    lbp_data,
   output logic          finish
);

   localparam int          N  = IMG_W * IMG_H;
   localparam int          CW = $clog2(IMG_W);
   localparam int          RW = $clog2(IMG_H + 2);
   localparam int unsigned WL = 2 * IMG_W + 3;
   localparam logic [AW-1:0] ADDR_LAST = AW'(N - 1);
   localparam logic [AW:0]   WIN_LAG   = (AW+1)'(IMG_W + 1);
`ifdef LBP_BORDER_EN
   localparam logic [AW-1:0] WR_LAST   = AW'(N - 1);
   localparam logic [AW:0]   FLUSH_BEG = (AW+1)'(N);
   localparam logic [AW:0]   FLUSH_END = (AW+1)'(N + IMG_W + 1);
`else
   localparam logic [AW-1:0] WR_LAST   = AW'(N - IMG_W - 2);
`endif

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t        state;
   logic          pend;
   logic [DW-1:0] win [WL];
   logic [CW-1:0] cap_c;
   logic [RW-1:0] cap_r;
   logic [AW:0]   cap_idx;
   logic          adv;
   logic          interior;
   logic          cmp_v;
   logic          cmp_int;
   logic [AW-1:0] cmp_addr;
   logic [DW-1:0] ctr;
   logic [7:0]    code;

   // A request goes out whenever the memory is ready during READ.
   always_comb begin
      gray_req = (state == READ) && gray_ready;
   end

   // Read sequencer: frame state, read address and completion flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         gray_addr <= '0;
         finish    <= 1'b0;
      end else begin
         case (state)
            IDLE:  if (gray_ready) state <= READ;
            READ:  if (gray_ready) begin
                      gray_addr <= gray_addr + AW'(1);
                      if (gray_addr == ADDR_LAST) state <= DRAIN;
                   end
            DRAIN: if (lbp_valid && lbp_addr == WR_LAST) begin
                      state  <= DONE;
                      finish <= 1'b1;
                   end
            DONE:  finish <= 1'b1;
            default: state <= IDLE;
         endcase
      end
   end

   // Advance the capture position; in border mode, virtual captures past the
   // frame end flush the trailing border addresses one per cycle.
   always_comb begin
`ifdef LBP_BORDER_EN
      adv = pend || (cap_idx >= FLUSH_BEG && cap_idx < FLUSH_END);
`else
      adv = pend;
`endif
      interior = (cap_r >= RW'(2)) && (cap_r < RW'(IMG_H)) && (cap_c >= CW'(2));
   end

   // Capture tracking: the pixel arriving now completes the window centred
   // IMG_W+1 pixels earlier, so its row/column decide whether that centre is interior.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend     <= 1'b0;
         cap_c    <= '0;
         cap_r    <= '0;
         cap_idx  <= '0;
         cmp_v    <= 1'b0;
         cmp_int  <= 1'b0;
         cmp_addr <= '0;
      end else begin
         pend <= gray_req;
         if (adv) begin
            cap_idx <= cap_idx + (AW+1)'(1);
            if (cap_c == CW'(IMG_W - 1)) begin
               cap_c <= '0;
               cap_r <= cap_r + RW'(1);
            end else begin
               cap_c <= cap_c + CW'(1);
            end
         end
`ifdef LBP_BORDER_EN
         cmp_v <= adv && (cap_idx >= WIN_LAG);
`else
         cmp_v <= pend && interior;
`endif
         cmp_int  <= interior;
         cmp_addr <= AW'(cap_idx - WIN_LAG);
      end
   end

   // Sliding window: win[0] is the newest pixel; it shifts only when data arrives.
   always_ff @(posedge clk) begin
      if (pend) begin
         win[0] <= gray_data;
         for (int unsigned i = 1; i < WL; i++) win[i] <= win[i-1];
      end
   end

   // Neighbour comparisons against the window centre.
   always_comb begin
      ctr     = win[IMG_W+1];
      code    = '0;
      code[0] = (win[2*IMG_W+2] >= ctr);
      code[1] = (win[2*IMG_W+1] >= ctr);
      code[2] = (win[2*IMG_W]   >= ctr);
      code[3] = (win[IMG_W+2]   >= ctr);
      code[4] = (win[IMG_W]     >= ctr);
      code[5] = (win[2]         >= ctr);
      code[6] = (win[1]         >= ctr);
      code[7] = (win[0]         >= ctr);
   end

   // Result register: the strobe lasts one cycle, and address/data hold between strobes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lbp_valid <= 1'b0;
         lbp_addr  <= '0;
         lbp_data  <= '0;
      end else begin
         lbp_valid <= cmp_v;
         if (cmp_v) begin
            lbp_addr <= cmp_addr;
            lbp_data <= cmp_int ? code : 8'h00;
         end
      end
   end

endmodule

// File: tb/tb_lbp_stream_engine.sv
// Self-checking bench for lbp_stream_engine: a 128x128 default instance and a
// 5x4 instance, with a behavioural pixel memory and an LBP reference model.
// Expectations adapt when LBP_BORDER_EN is defined.
module tb_lbp_stream_engine;

   localparam int BW = 128, BH = 128, BN = BW * BH;
   localparam int SW = 5,   SH = 4,   SN = SW * SH;
`ifdef LBP_BORDER_EN
   localparam int B_CNT = BN, B_FIRST = 0, B_LAST = BN - 1, S_CNT = SN;
`else
   localparam int B_CNT = 15876, B_FIRST = 129, B_LAST = 16254, S_CNT = 6;
`endif

   typedef struct {
      int pat;
      int stall_at;
      int cnt;
      int first;
      int last;
      int code;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [13:0] b_gaddr, b_laddr;
   logic        b_req, b_ready, b_valid, b_fin;
   logic [7:0]  b_gdata, b_ldata;
   logic [4:0]  s_gaddr, s_laddr;
   logic        s_req, s_ready, s_valid, s_fin;
   logic [7:0]  s_gdata, s_ldata;

   lbp_stream_engine #(.IMG_W(BW), .IMG_H(BH), .DW(8), .AW(14)) u_big (
      .clk(clk), .reset(reset), .gray_addr(b_gaddr), .gray_req(b_req),
      .gray_ready(b_ready), .gray_data(b_gdata), .lbp_addr(b_laddr),
      .lbp_valid(b_valid), .lbp_data(b_ldata), .finish(b_fin));

   lbp_stream_engine #(.IMG_W(SW), .IMG_H(SH), .DW(8), .AW(5)) u_small (
      .clk(clk), .reset(reset), .gray_addr(s_gaddr), .gray_req(s_req),
      .gray_ready(s_ready), .gray_data(s_gdata), .lbp_addr(s_laddr),
      .lbp_valid(s_valid), .lbp_data(s_ldata), .finish(s_fin));

   logic [7:0] b_img [BN];
   logic [7:0] s_img [SN];

   // Gray memory: data for the address requested at this edge appears next cycle.
   always @(posedge clk) begin
      if (b_req) b_gdata <= b_img[b_gaddr];
      if (s_req) s_gdata <= s_img[s_gaddr];
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(negedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] px(input bit big, input int r, input int c);
      if (big) return b_img[r*BW+c];
      return s_img[r*SW+c];
   endfunction

   function automatic bit interior(input int w, input int h, input int a);
      int r, c;
      r = a / w;
      c = a % w;
      return (r > 0) && (r < h - 1) && (c > 0) && (c < w - 1);
   endfunction

   // Reference LBP: bit set when neighbour >= centre; borders give 8'h00.
   function automatic logic [7:0] model(input bit big, input int a);
      int w, h, r, c;
      logic [7:0] ctr, res;
      w = big ? BW : SW;
      h = big ? BH : SH;
      r = a / w;
      c = a % w;
      if (!interior(w, h, a)) return 8'h00;
      ctr = px(big, r, c);
      res[0] = px(big, r-1, c-1) >= ctr;
      res[1] = px(big, r-1, c)   >= ctr;
      res[2] = px(big, r-1, c+1) >= ctr;
      res[3] = px(big, r,   c-1) >= ctr;
      res[4] = px(big, r,   c+1) >= ctr;
      res[5] = px(big, r+1, c-1) >= ctr;
      res[6] = px(big, r+1, c)   >= ctr;
      res[7] = px(big, r+1, c+1) >= ctr;
      return res;
   endfunction

   function automatic int b_exp_addr(input int e);
`ifdef LBP_BORDER_EN
      return e;
`else
      return (e / (BW - 2) + 1) * BW + e % (BW - 2) + 1;
`endif
   endfunction

   function automatic int s_exp_addr(input int e);
`ifdef LBP_BORDER_EN
      return e;
`else
      case (e)
         0: return 6;
         1: return 7;
         2: return 8;
         3: return 11;
         4: return 12;
         5: return 13;
         default: return 999;
      endcase
`endif
   endfunction

   int b_cnt, b_first, b_last, b_last_v, b_fin_cyc, b_req_cnt, b_req_bad, b_exp_code;
   bit b_fin_seen;
   int s_cnt, s_last_v, s_fin_cyc;
   bit s_fin_seen;

   // Big-instance monitor: result order/codes, read address sequence, finish timing.
   always @(negedge clk) begin
      int a;
      if (!reset) begin
         if (b_valid) begin
            a = b_exp_addr(b_cnt);
            check("b_lbp_addr", 32'(b_laddr), a);
            if (b_exp_code >= 0 && interior(BW, BH, a))
               check("b_lbp_code", 32'(b_ldata), b_exp_code);
            else
               check("b_lbp_data", 32'(b_ldata), 32'(model(1'b1, a)));
            if (b_cnt == 0) b_first = 32'(b_laddr);
            b_last   = 32'(b_laddr);
            b_last_v = cyc;
            b_cnt++;
         end
         if (b_req) begin
            if (32'(b_gaddr) != b_req_cnt) b_req_bad++;
            b_req_cnt++;
         end
         if (b_fin && !b_fin_seen) begin
            b_fin_seen = 1'b1;
            b_fin_cyc  = cyc;
         end
      end
   end

   // Small-instance monitor.
   always @(negedge clk) begin
      int a;
      if (!reset) begin
         if (s_valid) begin
            a = s_exp_addr(s_cnt);
            check("s_lbp_addr", 32'(s_laddr), a);
            check("s_lbp_data", 32'(s_ldata), 32'(model(1'b0, a)));
            s_last_v = cyc;
            s_cnt++;
         end
         if (s_fin && !s_fin_seen) begin
            s_fin_seen = 1'b1;
            s_fin_cyc  = cyc;
         end
      end
   end

   task automatic fill_big(input int pat);
      for (int r = 0; r < BH; r++)
         for (int c = 0; c < BW; c++)
            case (pat)
               0:       b_img[r*BW+c] = 8'h55;
               1:       b_img[r*BW+c] = 8'(c);
               default: b_img[r*BW+c] = 8'((c * 2) % 256);
            endcase
   endtask

   task automatic do_reset();
      b_ready = 1'b0;
      s_ready = 1'b0;
      reset   = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic check_big_reset_vals();
      check("rst_gray_addr", 32'(b_gaddr), 0);
      check("rst_gray_req",  32'(b_req),   0);
      check("rst_lbp_addr",  32'(b_laddr), 0);
      check("rst_lbp_valid", 32'(b_valid), 0);
      check("rst_lbp_data",  32'(b_ldata), 0);
      check("rst_finish",    32'(b_fin),   0);
   endtask

   // Run the big instance; optionally stall once at stall_at, or stop after stop_after reads.
   task automatic run_big(input int stall_at, input int stop_after);
      int n;
      b_cnt = 0; b_first = -1; b_last = -1; b_last_v = -1; b_fin_cyc = -1;
      b_req_cnt = 0; b_req_bad = 0; b_fin_seen = 1'b0;
      b_ready = 1'b1;
      n = 0;
      while (!b_fin_seen && n < 20000 && !(stop_after > 0 && b_req_cnt >= stop_after)) begin
         @(posedge clk);
         #1 n++;
         if (stall_at >= 0 && 32'(b_gaddr) == stall_at && b_req) begin
            b_ready = 1'b0;
            for (int k = 0; k < 7; k++) begin
               #1;
               check("stall_req",  32'(b_req),   0);
               check("stall_addr", 32'(b_gaddr), stall_at);
               @(posedge clk);
               #1 n++;
            end
            b_ready  = 1'b1;
            stall_at = -1;
         end
      end
   endtask

   task automatic check_big_frame(input vec_t v);
      check("b_finish_seen", 32'(b_fin_seen), 1);
      check("b_count",       b_cnt,     v.cnt);
      check("b_first",       b_first,   v.first);
      check("b_last",        b_last,    v.last);
      check("b_reads",       b_req_cnt, BN);
      check("b_read_seq",    b_req_bad, 0);
      check("b_fin_latency", b_fin_cyc - b_last_v, 1);
      repeat (3) @(posedge clk);
      #1;
      check("done_ignores_ready", 32'(b_req), 0);
      check("finish_held",        32'(b_fin), 1);
   endtask

   vec_t tbl [3];

   initial begin
      // Ramp: the equal-column neighbours satisfy >=, so bits 1 and 6 join 2, 4, 7.
      tbl[0] = '{pat: 0, stall_at: -1,          cnt: B_CNT, first: B_FIRST, last: B_LAST, code: 'hFF};
      tbl[1] = '{pat: 1, stall_at: -1,          cnt: B_CNT, first: B_FIRST, last: B_LAST, code: 'hD6};
      tbl[2] = '{pat: 2, stall_at: 40*BW + 60,  cnt: B_CNT, first: B_FIRST, last: B_LAST, code: -1};

      reset   = 1'b0;
      b_ready = 1'b0;
      s_ready = 1'b0;
      #1 reset = 1'b1;
      #1;
      check_big_reset_vals();
      check("rst_s_valid",  32'(s_valid), 0);
      check("rst_s_finish", 32'(s_fin),   0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < 3; i++) begin
         fill_big(tbl[i].pat);
         b_exp_code = tbl[i].code;
         run_big(tbl[i].stall_at, 0);
         check_big_frame(tbl[i]);
         do_reset();
      end

      // Abort mid-frame with an asynchronous reset, then run a full frame.
      fill_big(2);
      b_exp_code = -1;
      run_big(-1, 5000);
      check("b_partial_reads", 32'(b_req_cnt >= 5000), 1);
      reset = 1'b1;
      #1;
      check_big_reset_vals();
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      run_big(-1, 0);
      check_big_frame(tbl[2]);
      do_reset();

      // Small image with random pixels.
      for (int i = 0; i < SN; i++) s_img[i] = 8'($urandom_range(0, 255));
      s_cnt = 0; s_last_v = -1; s_fin_cyc = -1; s_fin_seen = 1'b0;
      s_ready = 1'b1;
      for (int n = 0; n < 200 && !s_fin_seen; n++) begin
         @(posedge clk);
         #1;
      end
      check("s_finish_seen", 32'(s_fin_seen), 1);
      check("s_count",       s_cnt, S_CNT);
      check("s_fin_latency", s_fin_cyc - s_last_v, 1);
      s_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
